// File: rtl/lc3_fetch_unit.sv
// lc3_fetch_unit: LC-3 instruction fetch FSM with wait-state timeout and IR handshake
module lc3_fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int WAIT_LIMIT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] pc_next,
  input  logic        ld_pc_ext,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        ir_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, HOLD, FAULT} state_t;
  localparam logic [3:0] LIM = 4'(WAIT_LIMIT - 1);
  state_t state;
  logic [15:0] mdr;
  logic [3:0] cnt;
  assign mem_rd = state == WAIT;
  assign fault = state == FAULT;
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      pc <= PC_RESET;
      mem_addr <= '0;
      ir <= '0;
      ir_valid <= 1'b0;
      mdr <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: begin
          if (ld_pc_ext) pc <= pc_next;
          if (Run) state <= ADDR;
        end
        ADDR: begin
          mem_addr <= pc;
          pc <= pc + 16'd1;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT:
          if (mem_ready) begin
            mdr <= mem_rdata;
            state <= LATCH;
          end else if (cnt == LIM) state <= FAULT;
          else cnt <= cnt + 4'd1;
        LATCH: begin
          ir <= mdr;
          ir_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD:
          if (ir_ack) begin
            ir_valid <= 1'b0;
            if (ld_pc_ext) pc <= pc_next;
            state <= Run ? ADDR : IDLE;
          end
        FAULT: ir_valid <= 1'b0;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb_lc3_fetch_unit: scoreboard bench; expected {mem_addr, ir} queued as memory data is driven
module tb_lc3_fetch_unit;
  logic Clk = 0, Reset = 0, Run = 0, ld_pc_ext = 0, mem_ready = 0, ir_ack = 0;
  logic [15:0] pc_next = 0, mem_rdata = 0;
  logic [15:0] mem_addr, pc, ir;
  logic mem_rd, ir_valid, fault;
  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  logic [15:0] mpc = 16'h0000;

  lc3_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .pc_next(pc_next), .ld_pc_ext(ld_pc_ext),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir_ack(ir_ack), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .pc(pc), .ir(ir), .ir_valid(ir_valid), .fault(fault)
  );

  always #5 Clk = ~Clk;

  task automatic fetch_one(input logic [15:0] data, input int delay);
    logic [31:0] e;
    int n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    checks++;
    if (mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_rd_timeout mem_rd=%b want 1", mem_rd); end
    repeat (delay) @(negedge Clk);
    mem_ready = 1; mem_rdata = data;
    sb.push_back({mpc, data});
    mpc = mpc + 16'd1;
    @(negedge Clk);
    mem_ready = 0; mem_rdata = 16'($urandom);
    n = 0;
    while (ir_valid !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
    checks++;
    if (ir_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid_timeout ir_valid=%b want 1", ir_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({mem_addr, ir} !== e) begin errors++; $display("FAIL fetch_addr_ir got %h/%h want %h/%h", mem_addr, ir, e[31:16], e[15:0]); end
    end
    checks++;
    if (pc !== mpc) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, mpc); end
  endtask

  task automatic ack(input logic run_v, input logic ld, input logic [15:0] nxt);
    Run = run_v; ir_ack = 1; ld_pc_ext = ld; pc_next = nxt;
    @(negedge Clk);
    ir_ack = 0; ld_pc_ext = 0;
    if (ld) mpc = nxt;
    checks++;
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL ack_clear ir_valid=%b want 0", ir_valid); end
  endtask

  task automatic test_reset;
    Reset = 1;
    repeat (2) @(negedge Clk);
    Reset = 0;
    mpc = 16'h0000;
    checks++;
    if ({pc, mem_addr, ir} !== 48'h0) begin errors++; $display("FAIL reset_regs got %h/%h/%h want 0/0/0", pc, mem_addr, ir); end
    checks++;
    if ({ir_valid, mem_rd, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ir_valid, mem_rd, fault}); end
  endtask

  task automatic test_fetch_latency;
    logic [31:0] e;
    Run = 1;
    @(negedge Clk);
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL lat_addr_rd mem_rd=%b want 0", mem_rd); end
    @(negedge Clk);
    checks++;
    if ({mem_rd, mem_addr, pc} !== {1'b1, 16'h0000, 16'h0001}) begin errors++; $display("FAIL lat_wait got %b/%h/%h want 1/0000/0001", mem_rd, mem_addr, pc); end
    mem_ready = 1; mem_rdata = 16'h1234;
    sb.push_back({mpc, 16'h1234});
    mpc = mpc + 16'd1;
    @(negedge Clk);
    mem_ready = 0;
    checks++;
    if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL lat_cycle3 got %b/%b want 0/0", ir_valid, mem_rd); end
    @(negedge Clk);
    e = sb.pop_front();
    checks++;
    if ({ir_valid, mem_addr, ir, pc} !== {1'b1, e, mpc}) begin errors++; $display("FAIL lat_cycle4 got %b/%h/%h/%h want 1/%h/%h/%h", ir_valid, mem_addr, ir, pc, e[31:16], e[15:0], mpc); end
    ack(0, 0, 16'h0);
  endtask

  task automatic test_wrap;
    ld_pc_ext = 1; pc_next = 16'hFFFF;
    @(negedge Clk);
    ld_pc_ext = 0;
    mpc = 16'hFFFF;
    checks++;
    if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_load pc=%h want ffff", pc); end
    Run = 1;
    fetch_one(16'hBEEF, 2);
    ack(0, 0, 16'h0);
  endtask

  task automatic test_redirect_ack;
    Run = 1;
    fetch_one(16'h5A5A, 0);
    ack(1, 1, 16'h3000);
    fetch_one(16'hC0DE, 1);
    ack(0, 0, 16'h0);
  endtask

  task automatic test_hold_stall;
    logic [15:0] ir_s;
    Run = 1;
    fetch_one(16'h7E57, 14);
    ir_s = ir;
    for (int i = 0; i < 10; i++) begin
      ld_pc_ext = i[0]; pc_next = 16'($urandom); Run = 1'($urandom);
      @(negedge Clk);
      checks++;
      if ({ir_valid, ir, pc} !== {1'b1, ir_s, mpc}) begin errors++; $display("FAIL hold_stall[%0d] got %b/%h/%h want 1/%h/%h", i, ir_valid, ir, pc, ir_s, mpc); end
    end
    ld_pc_ext = 0;
    ack(0, 0, 16'h0);
  endtask

  task automatic test_reset_mid_wait;
    int n = 0;
    Run = 1;
    while (mem_rd !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    @(negedge Clk);
    Reset = 1; mem_ready = 1; mem_rdata = 16'hDEAD;
    @(negedge Clk);
    Reset = 0; mem_ready = 0; Run = 0;
    mpc = 16'h0000;
    checks++;
    if ({ir, ir_valid, pc, mem_rd} !== {16'h0000, 1'b0, 16'h0000, 1'b0}) begin errors++; $display("FAIL reset_mid_wait got %h/%b/%h/%b want 0000/0/0000/0", ir, ir_valid, pc, mem_rd); end
    repeat (3) @(negedge Clk);
    checks++;
    if ({ir_valid, mem_rd} !== 2'b00) begin errors++; $display("FAIL reset_mid_wait_idle got %b want 00", {ir_valid, mem_rd}); end
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    Run = 1;
    fetch_one(16'h1001, 0);
    t0 = $time;
    for (int i = 0; i < 2; i++) begin
      ack(1, 0, 16'h0);
      fetch_one(16'h2002 + 16'(i), 0);
      t1 = $time;
      checks++;
      if (t1 - t0 != 40) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want 40", i, t1 - t0); end
      t0 = t1;
    end
    ack(0, 0, 16'h0);
  endtask

  task automatic test_run_drop;
    Run = 1;
    @(negedge Clk);
    Run = 0; mem_ready = 1; mem_rdata = 16'hBAD0; ld_pc_ext = 1; pc_next = 16'h7777;
    @(negedge Clk);
    mem_ready = 0; ld_pc_ext = 0;
    fetch_one(16'h0ABC, 0);
    ack(0, 0, 16'h0);
    repeat (3) @(negedge Clk);
    checks++;
    if ({mem_rd, pc} !== {1'b0, mpc}) begin errors++; $display("FAIL run_drop_idle got %b/%h want 0/%h", mem_rd, pc, mpc); end
  endtask

  task automatic test_fault;
    int n = 0, waits = 0;
    Run = 1;
    while (mem_rd !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    while (fault !== 1'b1 && n < 60) begin
      if (mem_rd === 1'b1) waits++;
      @(negedge Clk);
      n++;
    end
    Run = 0;
    checks++;
    if (waits != 15) begin errors++; $display("FAIL fault_wait_count got %0d want 15", waits); end
    checks++;
    if ({fault, mem_rd, ir_valid} !== 3'b100) begin errors++; $display("FAIL fault_flags got %b want 100", {fault, mem_rd, ir_valid}); end
    mem_ready = 1; ld_pc_ext = 1; Run = 1;
    repeat (3) @(negedge Clk);
    mem_ready = 0; ld_pc_ext = 0; Run = 0;
    checks++;
    if ({fault, mem_rd} !== 2'b10) begin errors++; $display("FAIL fault_sticky got %b want 10", {fault, mem_rd}); end
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    checks++;
    if ({fault, pc} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL fault_reset got %b/%h want 0/0000", fault, pc); end
  endtask

  initial begin
    @(negedge Clk);
    test_reset;
    test_fetch_latency;
    test_wrap;
    test_redirect_ack;
    test_hold_stall;
    test_reset_mid_wait;
    test_back_to_back;
    test_run_drop;
    test_fault;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
